// File: rtl/uxa_ps2_pkg.sv
// Shared PS/2 receive-path types: write-logic FSM state encoding.
package uxa_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BUMP  = 2'd2,
        WAIT  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/uxa_ps2_wrtlgc.sv
// PS/2 byte-to-FIFO write sequencer: one write then one pointer bump per frame, 1-cycle latency.
// No backpressure; a held frame parks in WAIT until the deserializer drops it.
module uxa_ps2_wrtlgc
    import uxa_ps2_pkg::*;
(
    input  logic sys_clk_i,
    input  logic sys_reset_i,
    input  logic frame_i,
    output logic we_o,
    output logic reset_o,
    output logic ptr_inc_o
);

    wr_state_t state;
    wr_state_t nxt;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = frame_i ? WRITE : IDLE;
            WRITE:   nxt = BUMP;
            BUMP:    nxt = frame_i ? WAIT : IDLE;
            WAIT:    nxt = frame_i ? WAIT : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered alongside the state, so they decode the state
    // register exactly and frame_i never reaches a port combinationally.
    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state     <= IDLE;
            we_o      <= 1'b0;
            reset_o   <= 1'b0;
            ptr_inc_o <= 1'b0;
        end else begin
            state     <= nxt;
            we_o      <= (nxt == WRITE);
            reset_o   <= (nxt == BUMP);
            ptr_inc_o <= (nxt == BUMP);
        end
    end

endmodule

// File: tb/tb_uxa_ps2_wrtlgc.sv
// Scoreboard bench for the PS/2 write sequencer: expected {we,reset,ptr_inc} queued per driven cycle.
module tb_uxa_ps2_wrtlgc;

    logic sys_clk_i = 1'b0;
    logic sys_reset_i;
    logic frame_i;
    logic we_o;
    logic reset_o;
    logic ptr_inc_o;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    uxa_ps2_wrtlgc dut (
        .sys_clk_i   (sys_clk_i),
        .sys_reset_i (sys_reset_i),
        .frame_i     (frame_i),
        .we_o        (we_o),
        .reset_o     (reset_o),
        .ptr_inc_o   (ptr_inc_o)
    );

    always #40 sys_clk_i = ~sys_clk_i;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive frame_i for one cycle (from a falling edge), queue the expected
    // outputs after the next rising edge, then compare at the following falling edge.
    task automatic step(input string tag, input logic f, input logic [2:0] exp);
        logic [2:0] want;
        frame_i = f;
        exp_q.push_back(exp);
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        want = exp_q.pop_front();
        check(tag, {we_o, reset_o, ptr_inc_o}, want);
        check({tag, "_excl"}, {2'b00, we_o & ptr_inc_o}, 3'b000);
    endtask

    initial begin
        sys_reset_i = 1'b1;
        frame_i     = 1'b0;
        #20;
        check("in_reset", {we_o, reset_o, ptr_inc_o}, 3'b000);
        #60;
        sys_reset_i = 1'b0;
        step("post_reset", 1'b0, 3'b000);

        // single byte
        step("single_we",   1'b1, 3'b100);
        step("single_bump", 1'b0, 3'b011);
        step("single_idle", 1'b0, 3'b000);

        // held frame: one write, one bump, then parked in WAIT
        step("held_we",   1'b1, 3'b100);
        step("held_bump", 1'b1, 3'b011);
        for (int i = 0; i < 3; i++) step("held_wait", 1'b1, 3'b000);
        step("held_exit", 1'b0, 3'b000);
        step("held_idle", 1'b0, 3'b000);

        // back-to-back bytes
        step("b2b_we0",   1'b1, 3'b100);
        step("b2b_bump0", 1'b1, 3'b011);
        step("b2b_gap",   1'b0, 3'b000);
        step("b2b_we1",   1'b1, 3'b100);
        step("b2b_bump1", 1'b1, 3'b011);
        step("b2b_idle",  1'b0, 3'b000);

        // glitch during WRITE/BUMP is ignored; high at the BUMP edge parks in WAIT
        step("glitch_we",   1'b1, 3'b100);
        step("glitch_bump", 1'b0, 3'b011);
        step("glitch_wait", 1'b1, 3'b000);
        step("glitch_wait2", 1'b1, 3'b000);
        step("glitch_idle", 1'b0, 3'b000);

        // reset mid-write: outputs clear without a clock, no bump follows
        step("abort_we", 1'b1, 3'b100);
        frame_i = 1'b0;
        #10 sys_reset_i = 1'b1;
        #5 check("abort_async", {we_o, reset_o, ptr_inc_o}, 3'b000);
        @(negedge sys_clk_i);
        check("abort_held", {we_o, reset_o, ptr_inc_o}, 3'b000);
        sys_reset_i = 1'b0;
        step("abort_nobump0", 1'b0, 3'b000);
        step("abort_nobump1", 1'b0, 3'b000);

        // first edge after reset release samples normally
        step("restart_we",   1'b1, 3'b100);
        step("restart_bump", 1'b0, 3'b011);
        step("restart_idle", 1'b0, 3'b000);

        check("queue_drained", 3'(exp_q.size()), 3'b000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Mutual exclusion also watched on every rising-edge settle point.
    always @(posedge sys_clk_i) begin
        #1;
        if (we_o && (reset_o || ptr_inc_o))
            check("we_overlap", {we_o, reset_o, ptr_inc_o}, 3'b100);
        if (reset_o !== ptr_inc_o)
            check("bump_pair", {1'b0, reset_o, ptr_inc_o}, {1'b0, reset_o, reset_o});
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/uxa_ps2_wrtlgc.md
UXA_PS2_WRTLGC -- requirements
Module: uxa_ps2_wrtlgc

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 SHALL have port sys_clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_reset_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port frame_i, input, 1: level from the PS/2 deserializer; high = complete byte held and ready for the FIFO.
REQ-005 SHALL have port we_o, output, 1: FIFO write enable; writes the deserializer byte at the current write pointer.
REQ-006 SHALL have port reset_o, output, 1: clears the deserializer (drops frame_i) for the next byte.
REQ-007 SHALL have port ptr_inc_o, output, 1: advances the FIFO write pointer by one.

Function
REQ-008 SHALL be a Moore FSM with states IDLE, WRITE, BUMP, WAIT; outputs decode from the registered state only, with no combinational path from frame_i to any output.
REQ-009 SHALL drive outputs as: IDLE and WAIT: all 0; WRITE: we_o=1, others 0; BUMP: reset_o=1, ptr_inc_o=1, we_o=0.
REQ-010 SHALL transition IDLE->WRITE on a rising edge with frame_i=1, and otherwise stay in IDLE.
REQ-011 SHALL transition WRITE->BUMP unconditionally after exactly one cycle, regardless of frame_i.
REQ-012 SHALL transition BUMP->IDLE if frame_i=0 at that edge, else BUMP->WAIT.
REQ-013 SHALL transition WAIT->IDLE when frame_i=0, and otherwise stay in WAIT; one frame SHALL yield exactly one write.
REQ-014 SHALL give latency: frame_i sampled high at edge N -> we_o high for cycle N..N+1 -> reset_o/ptr_inc_o high for cycle N+1..N+2, each exactly one cycle.
REQ-015 SHALL never assert we_o together with reset_o or ptr_inc_o.
REQ-016 SHALL always assert reset_o and ptr_inc_o together.
REQ-017 SHALL ignore frame_i pulses or glitches arriving in WRITE/BUMP; a frame_i still high after WAIT->IDLE is not possible, because WAIT exits only on low.
REQ-018 SHALL start a new write in the cycle after returning to IDLE when frame_i was low at the exit edge and is high at the next edge (back-to-back bytes).
REQ-019 SHALL return any unused state encoding to IDLE on the next edge.

Reset
REQ-020 SHALL force state=IDLE and we_o=reset_o=ptr_inc_o=0 immediately on sys_reset_i=1, without waiting for a clock.
REQ-021 SHALL abort an in-progress WRITE or BUMP on reset mid-operation, with no pointer increment issued.
REQ-022 SHALL sample frame_i normally from the first rising edge after sys_reset_i deasserts.

Structure
REQ-023 SHALL place the state encoding constants (IDLE, WRITE, BUMP, WAIT; 2 bits) in the shared package uxa_ps2_pkg.
REQ-024 SHALL be a single flat module with no sub-modules: one state register process plus next-state/output decode.

Verification
REQ-025 SHALL cover reset: clock period 80 ns; sys_reset_i pulsed 80 ns with frame_i=0 -> we_o=reset_o=ptr_inc_o=0 checked mid-cycle after release.
REQ-026 SHALL cover a single byte: frame_i=1 for one cycle, sampled at edge N -> at N+0.5 cycles we_o=1, reset_o=0, ptr_inc_o=0; at N+1.5 we_o=0, reset_o=1, ptr_inc_o=1; at N+2.5 all 0.
REQ-027 SHALL cover a held frame: frame_i held high 5 cycles -> exactly one we_o pulse and one ptr_inc_o pulse; FSM sits in WAIT until frame_i=0.
REQ-028 SHALL cover back-to-back bytes: frame_i=1 for 2 cycles, 0 for 1 cycle, then 1 for 2 cycles -> two distinct we_o pulses, each followed by a reset_o/ptr_inc_o pulse.
REQ-029 SHALL cover reset mid-operation: async reset asserted between edges while we_o=1 -> all outputs 0 within the same cycle; no ptr_inc_o follows.
REQ-030 SHALL check, for every scenario, that we_o and ptr_inc_o are never 1 in the same cycle.
